// File: rtl/seg_scan_if.sv
// Bundle between the clock core / display and seg_scan_mux: digit codes and
// scan control in, multiplexed segment bus and anode enables out.
interface seg_scan_if;
  logic       enable;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [6:0] seg4;
  logic [6:0] seg5;
  logic [5:0] blank_mask;
  logic [6:0] seg_out;
  logic [5:0] dig_an_n;
  logic [2:0] digit_idx;
  logic       frame_done;

  modport master (
    output enable, seg0, seg1, seg2, seg3, seg4, seg5, blank_mask,
    input  seg_out, dig_an_n, digit_idx, frame_done
  );

  modport slave (
    input  enable, seg0, seg1, seg2, seg3, seg4, seg5, blank_mask,
    output seg_out, dig_an_n, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Six-digit common-anode seven-segment scanner with a dark guard interval
// before every digit and a once-per-frame snapshot of the digit codes.
module seg_scan_mux #(
  parameter int DWELL_CYCLES = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input logic      clk,
  input logic      reset,
  seg_scan_if.slave bus
);

  localparam logic [16:0] DWELL_LAST = 17'(DWELL_CYCLES - 1);
  localparam logic [16:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 17'd0 : 17'(BLANK_CYCLES - 1);
  localparam logic [6:0]  SEG_DARK   = 7'h7F;
  localparam logic [5:0]  AN_DARK    = 6'h3F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t      state;
  logic [16:0] cnt;
  logic [2:0]  idx;
  logic [6:0]  shadow_seg [6];
  logic [5:0]  shadow_mask;

  logic [6:0]  in_seg [6];
  logic [6:0]  src_seg [6];
  logic [5:0]  src_mask;
  logic        capture;
  logic        dwell_end;
  logic        blank_end;
  logic        last_digit;
  logic [2:0]  next_idx;
  logic [2:0]  show_idx;
  logic [6:0]  show_raw;
  logic        show_masked;
  logic [6:0]  show_code;
  logic [5:0]  show_an;

  // On a snapshot edge the digit about to be lit must come from the live
  // inputs, since the shadows only take the new values on that same edge.
  always_comb begin
    in_seg[0]  = bus.seg0;
    in_seg[1]  = bus.seg1;
    in_seg[2]  = bus.seg2;
    in_seg[3]  = bus.seg3;
    in_seg[4]  = bus.seg4;
    in_seg[5]  = bus.seg5;
    dwell_end  = (cnt == DWELL_LAST);
    blank_end  = (cnt == BLANK_LAST);
    last_digit = (idx == 3'd5);
    next_idx   = last_digit ? 3'd0 : idx + 3'd1;
    capture    = (state == IDLE) || ((state == SHOW) && dwell_end && last_digit);
    for (int i = 0; i < 6; i++) begin
      src_seg[i] = capture ? in_seg[i] : shadow_seg[i];
    end
    src_mask = capture ? bus.blank_mask : shadow_mask;
    case (state)
      IDLE:    show_idx = 3'd0;
      SHOW:    show_idx = next_idx;
      default: show_idx = idx;
    endcase
    show_raw    = src_seg[0];
    show_masked = src_mask[0];
    for (int i = 1; i < 6; i++) begin
      if (show_idx == 3'(i)) begin
        show_raw    = src_seg[i];
        show_masked = src_mask[i];
      end
    end
    show_code = show_masked ? SEG_DARK : show_raw;
    show_an   = ~(6'b1 << show_idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      bus.seg_out    <= SEG_DARK;
      bus.dig_an_n   <= AN_DARK;
      bus.frame_done <= 1'b0;
      shadow_mask    <= 6'h3F;
      for (int i = 0; i < 6; i++) shadow_seg[i] <= SEG_DARK;
    end else if (!bus.enable) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      bus.seg_out    <= SEG_DARK;
      bus.dig_an_n   <= AN_DARK;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      cnt            <= cnt + 17'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          for (int i = 0; i < 6; i++) shadow_seg[i] <= in_seg[i];
          shadow_mask <= bus.blank_mask;
          if (BLANK_CYCLES == 0) begin
            state        <= SHOW;
            bus.seg_out  <= show_code;
            bus.dig_an_n <= show_an;
          end else begin
            state        <= BLANK;
            bus.seg_out  <= SEG_DARK;
            bus.dig_an_n <= AN_DARK;
          end
        end
        BLANK: begin
          if (blank_end) begin
            state        <= SHOW;
            cnt          <= '0;
            bus.seg_out  <= show_code;
            bus.dig_an_n <= show_an;
          end
        end
        SHOW: begin
          if (dwell_end) begin
            cnt <= '0;
            idx <= next_idx;
            if (last_digit) begin
              bus.frame_done <= 1'b1;
              for (int i = 0; i < 6; i++) shadow_seg[i] <= in_seg[i];
              shadow_mask <= bus.blank_mask;
            end
            // Code and anode switch together; with a guard both go dark first.
            if (BLANK_CYCLES == 0) begin
              bus.seg_out  <= show_code;
              bus.dig_an_n <= show_an;
            end else begin
              state        <= BLANK;
              bus.seg_out  <= SEG_DARK;
              bus.dig_an_n <= AN_DARK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two instances (guarded and guard-less) fed the same
// inputs, checked every cycle against a position-based model plus vectors.
module tb_seg_scan_mux;

  localparam int NDUT = 2;
  localparam int BL [NDUT] = '{2, 0};
  localparam int DW [NDUT] = '{4, 1};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] seg_in [6];
  logic [5:0] mask_in;

  int test_count = 0;
  int fail_count = 0;

  seg_scan_if if0 ();
  seg_scan_if if1 ();

  assign if0.enable = en;
  assign if1.enable = en;
  assign if0.blank_mask = mask_in;
  assign if1.blank_mask = mask_in;
  assign if0.seg0 = seg_in[0];
  assign if0.seg1 = seg_in[1];
  assign if0.seg2 = seg_in[2];
  assign if0.seg3 = seg_in[3];
  assign if0.seg4 = seg_in[4];
  assign if0.seg5 = seg_in[5];
  assign if1.seg0 = seg_in[0];
  assign if1.seg1 = seg_in[1];
  assign if1.seg2 = seg_in[2];
  assign if1.seg3 = seg_in[3];
  assign if1.seg4 = seg_in[4];
  assign if1.seg5 = seg_in[5];

  seg_scan_mux #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  seg_scan_mux #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expectations for the outputs following each edge.
  typedef struct {
    int         which;
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  exp_t       sb [$];
  bit         running [NDUT];
  int         kpos [NDUT];
  logic [6:0] snap [NDUT][6];
  logic [5:0] snap_mask [NDUT];

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      exp_t e;
      int per, p, dig, ph;
      e.which = d;
      e.seg = 7'h7F;
      e.an = 6'h3F;
      e.idx = 3'd0;
      e.fd = 1'b0;
      if (!rst_n || !en) begin
        running[d] = 1'b0;
      end else begin
        if (!running[d]) begin
          running[d] = 1'b1;
          kpos[d] = 0;
        end else begin
          kpos[d]++;
        end
        per = BL[d] + DW[d];
        p = kpos[d] % (6 * per);
        if (p == 0) begin
          for (int i = 0; i < 6; i++) snap[d][i] = seg_in[i];
          snap_mask[d] = mask_in;
        end
        dig = p / per;
        ph = p % per;
        e.idx = 3'(dig);
        e.fd = (kpos[d] > 0) && (p == 0);
        if (ph >= BL[d]) begin
          e.an = ~(6'b1 << dig);
          e.seg = snap_mask[d][dig] ? 7'h7F : snap[d][dig];
        end
      end
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.which == 0) begin
        check_output("dut0 seg_out", 32'(if0.seg_out), 32'(e.seg));
        check_output("dut0 dig_an_n", 32'(if0.dig_an_n), 32'(e.an));
        check_output("dut0 digit_idx", 32'(if0.digit_idx), 32'(e.idx));
        check_output("dut0 frame_done", 32'(if0.frame_done), 32'(e.fd));
      end else begin
        check_output("dut1 seg_out", 32'(if1.seg_out), 32'(e.seg));
        check_output("dut1 dig_an_n", 32'(if1.dig_an_n), 32'(e.an));
        check_output("dut1 digit_idx", 32'(if1.digit_idx), 32'(e.idx));
        check_output("dut1 frame_done", 32'(if1.frame_done), 32'(e.fd));
      end
    end
  end

  // Directed vectors against the guarded instance (2 dark + 4 lit per digit).
  typedef struct {
    logic            rst_n;
    logic            en;
    logic [5:0][6:0] segs;
    logic [5:0]      mask;
    int              cycles;
    logic [6:0]      exp_seg;
    logic [5:0]      exp_an;
    logic [2:0]      exp_idx;
    logic            exp_fd;
  } vec_t;

  localparam logic [5:0][6:0] SEGS = {7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01};

  task automatic apply_stimulus(input vec_t v, input int n);
    rst_n = v.rst_n;
    en = v.en;
    for (int i = 0; i < 6; i++) seg_in[i] = v.segs[i];
    mask_in = v.mask;
    repeat (v.cycles) @(negedge clk);
    check_output($sformatf("vec%0d seg_out", n), 32'(if0.seg_out), 32'(v.exp_seg));
    check_output($sformatf("vec%0d dig_an_n", n), 32'(if0.dig_an_n), 32'(v.exp_an));
    check_output($sformatf("vec%0d digit_idx", n), 32'(if0.digit_idx), 32'(v.exp_idx));
    check_output($sformatf("vec%0d frame_done", n), 32'(if0.frame_done), 32'(v.exp_fd));
  endtask

  task automatic wait_an(input logic [5:0] an, input int limit, input string name, output int taken);
    taken = 0;
    while (if0.dig_an_n !== an && taken < limit) begin
      @(negedge clk);
      taken++;
    end
    if (if0.dig_an_n !== an) begin
      check_output({name, " timeout"}, 32'(if0.dig_an_n), 32'(an));
    end
  endtask

  task automatic wait_fd(input bit which, input int limit, input string name, output int taken);
    taken = 0;
    do begin
      @(negedge clk);
      taken++;
    end while (((which ? if1.frame_done : if0.frame_done) !== 1'b1) && taken < limit);
    if ((which ? if1.frame_done : if0.frame_done) !== 1'b1) begin
      check_output({name, " timeout"}, 32'(which ? if1.frame_done : if0.frame_done), 32'd1);
    end
  endtask

  vec_t vecs [11];
  int   t;
  int   fd_seen;

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mask_in = 6'h00;
    for (int i = 0; i < 6; i++) seg_in[i] = SEGS[i];
    vecs[0]  = '{1'b0, 1'b0, SEGS, 6'h00, 2,  7'h7F, 6'h3F, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, SEGS, 6'h00, 1,  7'h7F, 6'h3F, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, SEGS, 6'h00, 2,  7'h01, 6'h3E, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, SEGS, 6'h00, 6,  7'h4F, 6'h3D, 3'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, SEGS, 6'h00, 10, 7'h7F, 6'h3F, 3'd3, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, SEGS, 6'h00, 5,  7'h06, 6'h37, 3'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, SEGS, 6'h00, 13, 7'h7F, 6'h3F, 3'd0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, SEGS, 6'h00, 1,  7'h7F, 6'h3F, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, SEGS, 6'h20, 33, 7'h24, 6'h1F, 3'd5, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, SEGS, 6'h20, 36, 7'h7F, 6'h1F, 3'd5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, SEGS, 6'h20, 1,  7'h7F, 6'h3F, 3'd0, 1'b0};

    @(negedge clk);
    for (int n = 0; n < 11; n++) apply_stimulus(vecs[n], n);

    // Mid-frame code change must not tear the current frame.
    mask_in = 6'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    wait_an(6'h3D, 20, "digit1 lit", t);
    seg_in[2] = 7'h00;
    wait_an(6'h3B, 20, "digit2 lit", t);
    check_output("seg2 held this frame", 32'(if0.seg_out), 32'h12);
    wait_fd(1'b0, 40, "first frame_done", t);
    wait_fd(1'b0, 40, "second frame_done", t);
    check_output("frame period", 32'(t), 32'd36);
    wait_an(6'h3B, 40, "digit2 next frame", t);
    check_output("seg2 updated next frame", 32'(if0.seg_out), 32'h00);

    // Disable while digit 3 is lit, then restart from digit 0.
    wait_an(6'h37, 40, "digit3 lit", t);
    en = 1'b0;
    @(negedge clk);
    check_output("disable anodes dark", 32'(if0.dig_an_n), 32'h3F);
    check_output("disable segs dark", 32'(if0.seg_out), 32'h7F);
    @(negedge clk);
    en = 1'b1;
    fd_seen = 0;
    t = 0;
    while (if0.dig_an_n !== 6'h3E && t < 10) begin
      @(negedge clk);
      t++;
      if (if0.frame_done === 1'b1) fd_seen++;
    end
    check_output("restart latency", 32'(t), 32'd3);
    check_output("no frame_done at restart", 32'(fd_seen), 32'd0);

    // One-edge reset pulse in the middle of digit 4's dwell.
    wait_an(6'h2F, 40, "digit4 lit", t);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("reset anodes", 32'(if0.dig_an_n), 32'h3F);
    check_output("reset segs", 32'(if0.seg_out), 32'h7F);
    check_output("reset idx", 32'(if0.digit_idx), 32'd0);
    rst_n = 1'b1;
    wait_an(6'h3E, 10, "resume digit0", t);
    check_output("resume idx", 32'(if0.digit_idx), 32'd0);

    // Guard-less instance: one digit per clock, frame every six clocks.
    wait_fd(1'b1, 20, "dut1 frame_done", t);
    wait_fd(1'b1, 20, "dut1 next frame_done", t);
    check_output("dut1 frame period", 32'(t), 32'd6);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
